// File: rtl/bjack_dealer_if.sv
// Card handshake bus shared by the blackjack player controller (master) and the dealer (slave).
interface bjack_dealer_if;
  logic       next_c;
  logic       new_g;
  logic [3:0] card;
  logic       new_c;

  modport master (output next_c, output new_g, input card, input new_c);
  modport slave  (input next_c, input new_g, output card, output new_c);
endinterface

// File: rtl/bjack_dealer.sv
// Blackjack card shoe/dealer: serves NEXT_C requests with LFSR-drawn cards and tracks the shoe.
// Optional macro BJACK_DEALER_STACK_EN adds i_stack_vld/i_stack_card to load a fixed card in DRAW.
module bjack_dealer #(
  parameter logic [7:0] SEED      = 8'hA5,
  parameter int         DECK_SIZE = 52,
  parameter int         TIMEOUT   = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  bjack_dealer_if.slave        io_card_bus,
`ifdef BJACK_DEALER_STACK_EN
  input  logic                 i_stack_vld,
  input  logic [3:0]           i_stack_card,
`endif
  output logic [5:0]           o_dealt,
  output logic                 o_shuffle,
  output logic                 o_err
);

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    DRAW    = 5'b00010,
    OFFER   = 5'b00100,
    RELEASE = 5'b01000,
    SHUF    = 5'b10000
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_lfsr;
  logic [3:0] r_card;
  logic [5:0] r_dealt;
  logic [7:0] r_tmo;
  logic       r_err;

  logic       w_stack_vld;
  logic [3:0] w_stack_card;
  logic [7:0] w_lfsr_nxt;
  logic       w_accept;
  logic [3:0] w_card_nxt;
  logic       w_shoe_full;
  logic       w_tmo_hit;
  logic       w_load;
  logic       w_tmo_inc;
  logic       w_err_set;
  logic       w_dealt_clr;

  function automatic logic [3:0] card_map(input logic [3:0] r);
    if (r == 4'd0) return 4'd11;
    if (r <= 4'd8) return r + 4'd1;
    return 4'd10;
  endfunction

`ifdef BJACK_DEALER_STACK_EN
  assign w_stack_vld  = i_stack_vld;
  assign w_stack_card = i_stack_card;
`else
  assign w_stack_vld  = 1'b0;
  assign w_stack_card = 4'd0;
`endif

  assign w_lfsr_nxt  = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? 8'hB8 : 8'h00);
  assign w_accept    = w_stack_vld || (r_lfsr[3:0] <= 4'd12);
  assign w_card_nxt  = w_stack_vld ? w_stack_card : card_map(r_lfsr[3:0]);
  assign w_shoe_full = (r_dealt == 6'(DECK_SIZE));
  assign w_tmo_hit   = (r_tmo == 8'(TIMEOUT - 1));

  always_ff @(posedge i_clock) begin
    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    if (!i_reset_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_tmo_inc   = 1'b0;
    w_err_set   = 1'b0;
    w_dealt_clr = 1'b0;
    if (io_card_bus.new_g) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        // A new game aborted in RELEASE can leave a full shoe here; shuffle before serving.
        IDLE:    if (w_shoe_full)             w_state_nxt = SHUF;
                 else if (io_card_bus.next_c) w_state_nxt = DRAW;
        DRAW:    if (w_accept) begin
                   w_load      = 1'b1;
                   w_state_nxt = OFFER;
                 end
        OFFER:   if (!io_card_bus.next_c) begin
                   w_state_nxt = RELEASE;
                 end else if (w_tmo_hit) begin
                   w_err_set   = 1'b1;
                   w_state_nxt = RELEASE;
                 end else begin
                   w_tmo_inc   = 1'b1;
                 end
        RELEASE: w_state_nxt = w_shoe_full ? SHUF : IDLE;
        SHUF:    begin
                   w_dealt_clr = 1'b1;
                   w_state_nxt = IDLE;
                 end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_lfsr  <= SEED;
      r_card  <= 4'd0;
      r_dealt <= 6'd0;
      r_tmo   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_lfsr <= w_lfsr_nxt;
      if (w_load) begin
        r_card  <= w_card_nxt;
        r_dealt <= r_dealt + 6'd1;
        r_tmo   <= 8'd0;
      end else if (w_tmo_inc) begin
        r_tmo   <= r_tmo + 8'd1;
      end
      if (w_dealt_clr) r_dealt <= 6'd0;
      if (w_err_set)   r_err   <= 1'b1;
    end
  end

  assign io_card_bus.card  = r_card;
  assign io_card_bus.new_c = (r_state == OFFER);
  assign o_shuffle         = (r_state == SHUF);
  assign o_dealt           = r_dealt;
  assign o_err             = r_err;

endmodule

// File: tb/tb_bjack_dealer.sv
// Self-checking bench for bjack_dealer: an LFSR reference model predicts each card and its
// latency into a scoreboard queue that is popped when NEW_C rises.
module tb_bjack_dealer;

  localparam logic [7:0] SEED = 8'hA5;
  localparam int         DECK = 52;
  localparam int         TMO  = 16;
  localparam logic [3:0] CARD_TBL [16] = '{4'd11, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                                           4'd9, 4'd10, 4'd10, 4'd10, 4'd10, 4'd0, 4'd0, 4'd0};

  typedef struct {
    logic [3:0] card;
    logic [5:0] dealt;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] dealt;
  logic       shuffle;
  logic       err;
`ifdef BJACK_DEALER_STACK_EN
  logic       stack_vld;
  logic [3:0] stack_card;
`endif

  bjack_dealer_if bus ();

  bjack_dealer #(.SEED(SEED), .DECK_SIZE(DECK), .TIMEOUT(TMO)) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .io_card_bus (bus),
`ifdef BJACK_DEALER_STACK_EN
    .i_stack_vld (stack_vld),
    .i_stack_card(stack_card),
`endif
    .o_dealt     (dealt),
    .o_shuffle   (shuffle),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         m_dealt = 0;
  int         shuf_cnt = 0;
  logic [7:0] m_lfsr;
  exp_t       sb[$];

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  always @(posedge clk) m_lfsr <= rst_n ? lfsr_step(m_lfsr) : SEED;
  always @(negedge clk) if (shuffle === 1'b1) shuf_cnt++;

  // Call at a negedge with the dealer in IDLE; returns at the first negedge with NEW_C high.
  task automatic request(input string tag, input bit use_stack, input logic [3:0] stack_val,
                         output int lat);
    exp_t       e, got;
    logic [7:0] l;
    l     = lfsr_step(m_lfsr);
    e.lat = 2;
    if (!use_stack)
      while (CARD_TBL[l[3:0]] == 4'd0) begin
        l = lfsr_step(l);
        e.lat++;
      end
    e.card = use_stack ? stack_val : CARD_TBL[l[3:0]];
    m_dealt++;
    e.dealt = 6'(m_dealt);
    sb.push_back(e);
`ifdef BJACK_DEALER_STACK_EN
    stack_vld  = use_stack;
    stack_card = stack_val;
`endif
    bus.next_c = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.new_c !== 1'b1 && lat < 40);
    got = sb.pop_front();
    n_tests++;
    if (lat !== got.lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", tag, lat, got.lat);
    end
    n_tests++;
    if (bus.card !== got.card) begin
      n_fail++;
      $display("FAIL %s card: got %0d expected %0d", tag, bus.card, got.card);
    end
    n_tests++;
    if (dealt !== got.dealt) begin
      n_fail++;
      $display("FAIL %s dealt: got %0d expected %0d", tag, dealt, got.dealt);
    end
`ifdef BJACK_DEALER_STACK_EN
    stack_vld = 1'b0;
`endif
  endtask

  // Full handshake: NEXT_C drops one cycle after NEW_C, NEW_C must follow one cycle later.
  task automatic deal(input string tag, output int lat);
    request(tag, 1'b0, 4'd0, lat);
    @(negedge clk);
    bus.next_c = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.new_c !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: new_c got %b expected 0", tag, bus.new_c);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    m_dealt  = 0;
    shuf_cnt = 0;
    sb.delete();
    n_tests++;
    if ({bus.new_c, bus.card, dealt, err, shuffle} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset: new_c/card/dealt/err/shuffle got %b/%0d/%0d/%b/%b expected all 0",
               bus.new_c, bus.card, dealt, err, shuffle);
    end
  endtask

  task automatic test_basic();
    int lat;
    for (int i = 0; i < 4; i++) deal($sformatf("basic%0d", i), lat);
  endtask

  // Wait until the model says the next DRAW sees nibble `want`, then request.
  task automatic test_forced(input logic [3:0] want);
    logic [7:0] l;
    int         w = 0;
    int         lat;
    l = lfsr_step(m_lfsr);
    while (l[3:0] != want && w < 300) begin
      @(negedge clk);
      w++;
      l = lfsr_step(m_lfsr);
    end
    n_tests++;
    if (w >= 300) begin
      n_fail++;
      $display("FAIL forced%0d search: waited %0d expected <300", want, w);
    end
    deal($sformatf("forced%0d", want), lat);
    if (want == 4'd0) begin
      n_tests++;
      if (bus.card !== 4'd11) begin
        n_fail++;
        $display("FAIL ace card: got %0d expected 11", bus.card);
      end
    end else begin
      n_tests++;
      if (lat < 3) begin
        n_fail++;
        $display("FAIL reject latency: got %0d expected >=3", lat);
      end
    end
  endtask

  task automatic test_new_game();
    int lat;
    request("newg", 1'b0, 4'd0, lat);
    bus.new_g  = 1'b1;
    bus.next_c = 1'b0;
    @(negedge clk);
    bus.new_g = 1'b0;
    n_tests++;
    if (bus.new_c !== 1'b0 || dealt !== 6'(m_dealt)) begin
      n_fail++;
      $display("FAIL newg abort: new_c/dealt got %b/%0d expected 0/%0d", bus.new_c, dealt, m_dealt);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat;
    int cnt = 0;
    request("tmo", 1'b0, 4'd0, lat);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo err early: got %b expected 0", err);
    end
    while (bus.new_c === 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    n_tests++;
    if (cnt !== TMO || err !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo offer cycles/err: got %0d/%b expected %0d/1", cnt, err, TMO);
    end
    bus.next_c = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (err !== 1'b1 || bus.new_c !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo sticky: err/new_c got %b/%b expected 1/0", err, bus.new_c);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    test_reset();
    for (int i = 1; i < DECK; i++) deal($sformatf("shoe%0d", i), lat);
    n_tests++;
    if (shuf_cnt !== 0) begin
      n_fail++;
      $display("FAIL early shuffle: pulses got %0d expected 0", shuf_cnt);
    end
    deal("shoe_last", lat);
    n_tests++;
    if (shuffle !== 1'b1 || dealt !== 6'(DECK)) begin
      n_fail++;
      $display("FAIL shuffle pulse: shuffle/dealt got %b/%0d expected 1/%0d", shuffle, dealt, DECK);
    end
    @(negedge clk);
    m_dealt = 0;
    n_tests++;
    if (shuffle !== 1'b0 || dealt !== 6'd0 || shuf_cnt !== 1) begin
      n_fail++;
      $display("FAIL after shuffle: shuffle/dealt/pulses got %b/%0d/%0d expected 0/0/1",
               shuffle, dealt, shuf_cnt);
    end
    deal("fresh_shoe", lat);
  endtask

`ifdef BJACK_DEALER_STACK_EN
  task automatic test_stack();
    int lat;
    request("stack", 1'b1, 4'd7, lat);
    bus.next_c = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.card !== 4'd7) begin
      n_fail++;
      $display("FAIL stack hold: card got %0d expected 7", bus.card);
    end
  endtask
`endif

  initial begin
    bus.next_c = 1'b0;
    bus.new_g  = 1'b0;
    rst_n      = 1'b0;
`ifdef BJACK_DEALER_STACK_EN
    stack_vld  = 1'b0;
    stack_card = 4'd0;
`endif
    @(negedge clk);
    test_reset();
    test_basic();
    test_forced(4'd0);
    test_forced(4'd13);
    test_new_game();
    test_timeout();
    test_back_to_back();
`ifdef BJACK_DEALER_STACK_EN
    test_stack();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
